// File: rtl/delay_mem_responder_pkg.sv
// Shared definitions for the delay-line memory blocks (delay_mem_responder,
// delay_master): responder FSM states, sample format and address sizing.
package delay_mem_responder_pkg;

   // Responder handshake states.
   typedef enum logic [2:0] {
      INIT,
      IDLE,
      WRITE,
      READ,
      HOLD
   } mem_state_t;

   // Width of one stored delay sample: signed Q1.15.
   localparam int unsigned DELAY_FORMAT = 16;

   // Address width for a memory of 'words' entries (never below 1 bit).
   function automatic int unsigned addr_width_for(input int unsigned words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/delay_mem_ram.sv
// Single-port synchronous RAM with a read_latency-deep registered read path.
//   clk    : clock, rising edge
//   we     : write enable, writes wdata to addr
//   addr   : shared read/write address (caller keeps it below depth)
//   wdata  : write data
//   rdata  : word at addr, read_latency cycles after addr is presented
// Contents have no reset; they are cleared by the owner's sweep.
module delay_mem_ram #(
   parameter int unsigned data_width   = 16,
   parameter int unsigned depth        = 8192,
   parameter int unsigned addr_width   = 13,
   parameter int unsigned read_latency = 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [addr_width-1:0] addr,
   input  logic [data_width-1:0] wdata,
   output logic [data_width-1:0] rdata
);

   logic [data_width-1:0] mem  [depth];
   logic [data_width-1:0] pipe [read_latency];

   // Read-before-write on the array; further stages only delay the word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      pipe[0] <= mem[addr];
      for (int unsigned i = 1; i < read_latency; i++) begin
         pipe[i] <= pipe[i-1];
      end
   end

   assign rdata = pipe[read_latency-1];

endmodule

// File: rtl/delay_mem_responder.sv
// Memory responder for the delay line: clears its RAM after reset, then serves
// level-held read/write requests one at a time with pulsed completion.
//   clk            : clock, rising edge
//   reset_n        : asynchronous active-low reset
//   mem_read_req   : read request, held until mem_read_valid
//   mem_write_req  : write request, held until mem_write_ack (wins over read)
//   mem_read_addr  : read address
//   mem_write_addr : write address
//   mem_data_out   : write data from the initiator
//   mem_data_in    : read data, held until the next read completes
//   mem_read_valid : one-cycle read completion pulse
//   mem_write_ack  : one-cycle write completion pulse
//   init_done      : high once the clear sweep has finished
//   addr_error     : pulses with ack/valid when the address was >= memory_size
module delay_mem_responder
   import delay_mem_responder_pkg::*;
#(
   parameter  int unsigned data_width   = DELAY_FORMAT,
   parameter  int unsigned memory_size  = 8192,
   parameter  int unsigned read_latency = 1,
   localparam int unsigned addr_width   = addr_width_for(memory_size)
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         mem_read_req,
   input  logic                         mem_write_req,
   input  logic [addr_width-1:0]        mem_read_addr,
   input  logic [addr_width-1:0]        mem_write_addr,
   input  logic signed [data_width-1:0] mem_data_out,
   output logic signed [data_width-1:0] mem_data_in,
   output logic                         mem_read_valid,
   output logic                         mem_write_ack,
   output logic                         init_done,
   output logic                         addr_error
);

   localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(memory_size - 1);
   localparam logic [2:0]            LAT       = 3'(read_latency);

   mem_state_t state, state_nxt;

   logic [addr_width-1:0] sweep_cnt;
   logic [addr_width-1:0] addr_q;
   logic [data_width-1:0] wdata_q;
   logic                  addr_bad_q;
   logic                  hold_wr_q;   // HOLD watches the write line, else the read line
   logic [2:0]            lat_cnt;

   logic                  ram_we;
   logic [addr_width-1:0] ram_addr;
   logic [data_width-1:0] ram_wdata;
   logic [data_width-1:0] ram_rdata;

   function automatic logic in_range(input logic [addr_width-1:0] a);
      return 32'(a) < memory_size;
   endfunction

   delay_mem_ram #(
      .data_width  (data_width),
      .depth       (memory_size),
      .addr_width  (addr_width),
      .read_latency(read_latency)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .wdata(ram_wdata),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // Out-of-range accesses park the RAM address at 0 and suppress the write,
   // so the array is never indexed past its end.
   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      case (state)
         INIT: begin
            ram_we   = 1'b1;
            ram_addr = sweep_cnt;
            if (sweep_cnt == LAST_ADDR) begin
               state_nxt = IDLE;
            end
         end
         IDLE: begin
            if (mem_write_req) begin
               state_nxt = WRITE;
            end else if (mem_read_req) begin
               state_nxt = READ;
            end
         end
         WRITE: begin
            ram_we    = !addr_bad_q;
            ram_addr  = addr_bad_q ? '0 : addr_q;
            ram_wdata = wdata_q;
            state_nxt = HOLD;
         end
         READ: begin
            ram_addr = addr_bad_q ? '0 : addr_q;
            if (lat_cnt == LAT) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (hold_wr_q ? !mem_write_req : !mem_read_req) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = INIT;
      endcase
   end

   // lat_cnt counts edges spent in READ; the address reaches the RAM on the
   // first of them, so the word is at the pipe output once lat_cnt == LAT.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sweep_cnt      <= '0;
         init_done      <= 1'b0;
         mem_write_ack  <= 1'b0;
         mem_read_valid <= 1'b0;
         addr_error     <= 1'b0;
         mem_data_in    <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         addr_bad_q     <= 1'b0;
         hold_wr_q      <= 1'b0;
         lat_cnt        <= '0;
      end else begin
         mem_write_ack  <= 1'b0;
         mem_read_valid <= 1'b0;
         addr_error     <= 1'b0;
         case (state)
            INIT: begin
               sweep_cnt <= sweep_cnt + addr_width'(1);
               if (sweep_cnt == LAST_ADDR) begin
                  init_done <= 1'b1;
               end
            end
            IDLE: begin
               lat_cnt <= '0;
               if (mem_write_req) begin
                  addr_q     <= mem_write_addr;
                  wdata_q    <= mem_data_out;
                  addr_bad_q <= !in_range(mem_write_addr);
                  hold_wr_q  <= 1'b1;
               end else if (mem_read_req) begin
                  addr_q     <= mem_read_addr;
                  addr_bad_q <= !in_range(mem_read_addr);
                  hold_wr_q  <= 1'b0;
               end
            end
            WRITE: begin
               mem_write_ack <= 1'b1;
               addr_error    <= addr_bad_q;
            end
            READ: begin
               lat_cnt <= lat_cnt + 3'd1;
               if (lat_cnt == LAT) begin
                  mem_read_valid <= 1'b1;
                  addr_error     <= addr_bad_q;
                  mem_data_in    <= addr_bad_q ? '0 : ram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_mem_responder.sv
module tb_delay_mem_responder;

   localparam int unsigned DW     = 16;
   localparam int unsigned AW     = 4;
   localparam int unsigned SIZE_A = 16;
   localparam int unsigned SIZE_B = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 reset_n = 1'b1;
   logic                 rd_req  = 1'b0;
   logic                 wr_req  = 1'b0;
   logic [AW-1:0]        rd_addr = '0;
   logic [AW-1:0]        wr_addr = '0;
   logic signed [DW-1:0] wdata   = '0;

   logic signed [DW-1:0] rdata [2];
   logic                 rv    [2];
   logic                 wa    [2];
   logic                 idone [2];
   logic                 aerr  [2];

   delay_mem_responder #(.data_width(DW), .memory_size(SIZE_A), .read_latency(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .mem_read_req(rd_req), .mem_write_req(wr_req),
      .mem_read_addr(rd_addr), .mem_write_addr(wr_addr), .mem_data_out(wdata),
      .mem_data_in(rdata[0]), .mem_read_valid(rv[0]), .mem_write_ack(wa[0]),
      .init_done(idone[0]), .addr_error(aerr[0]));

   delay_mem_responder #(.data_width(DW), .memory_size(SIZE_B), .read_latency(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .mem_read_req(rd_req), .mem_write_req(wr_req),
      .mem_read_addr(rd_addr), .mem_write_addr(wr_addr), .mem_data_out(wdata),
      .mem_data_in(rdata[1]), .mem_read_valid(rv[1]), .mem_write_ack(wa[1]),
      .init_done(idone[1]), .addr_error(aerr[1]));

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
   } rd_exp_t;

   rd_exp_t       rd_q [2][$];
   logic          wr_q [2][$];
   logic [DW-1:0] model [2][16];
   int unsigned   size_of [2] = '{SIZE_A, SIZE_B};
   int            compared    = 0;
   int            mismatched  = 0;

   // Scoreboard: every ack/valid pulse is matched against the next expectation.
   always @(negedge clk) begin
      rd_exp_t re;
      logic    we_err;
      if (reset_n) begin
         for (int d = 0; d < 2; d++) begin
            if (rv[d] && wa[d]) begin
               compared++; mismatched++;
               $display("FAIL overlap dut%0d: ack=1 valid=1, required not both", d);
            end
            if (wa[d]) begin
               compared++;
               if (wr_q[d].size() == 0) begin
                  mismatched++;
                  $display("FAIL unexpected_ack dut%0d: got ack, required none", d);
               end else begin
                  we_err = wr_q[d].pop_front();
                  if (aerr[d] !== we_err) begin
                     mismatched++;
                     $display("FAIL ack_addr_error dut%0d: got %b, required %b", d, aerr[d], we_err);
                  end
               end
            end
            if (rv[d]) begin
               compared++;
               if (rd_q[d].size() == 0) begin
                  mismatched++;
                  $display("FAIL unexpected_valid dut%0d: got valid, required none", d);
               end else begin
                  re = rd_q[d].pop_front();
                  if (rdata[d] !== re.data || aerr[d] !== re.err) begin
                     mismatched++;
                     $display("FAIL read_data dut%0d: got %h err=%b, required %h err=%b",
                              d, rdata[d], aerr[d], re.data, re.err);
                  end
               end
            end
         end
      end
   end

   // Returns posedges until the pulse (0: ack, 1: valid) on dut_a, -1 on timeout.
   task automatic wait_pulse(input int which, output int cycles);
      cycles = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if ((which == 0) ? wa[0] : rv[0]) begin
            cycles = k;
            return;
         end
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 16; i++) model[d][i] = '0;
   endtask

   // Releases reset at a falling edge and reports posedges until init_done.
   task automatic release_and_measure(output int first [2]);
      first = '{0, 0};
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++)
            if (idone[d] && first[d] == 0) first[d] = k;
         if (first[0] != 0 && first[1] != 0) break;
      end
   endtask

   task automatic do_write(input int addr, input logic [DW-1:0] data,
                           input bit hold_extra, output int lat);
      for (int d = 0; d < 2; d++) begin
         wr_q[d].push_back(addr >= int'(size_of[d]));
         if (addr < int'(size_of[d])) model[d][addr] = data;
      end
      wr_addr = AW'(addr);
      wdata   = data;
      wr_req  = 1'b1;
      wait_pulse(0, lat);
      if (hold_extra) begin
         @(posedge clk); #1;
      end
      wr_req = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic do_read(input int addr, output int lat);
      rd_exp_t re;
      for (int d = 0; d < 2; d++) begin
         re.err  = (addr >= int'(size_of[d]));
         re.data = re.err ? '0 : model[d][addr];
         rd_q[d].push_back(re);
      end
      rd_addr = AW'(addr);
      rd_req  = 1'b1;
      wait_pulse(1, lat);
      rd_req = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      int first [2];
      int exp_init [2];
      exp_init = '{int'(SIZE_A), int'(SIZE_B)};
      #1 reset_n = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         compared++;
         if (rv[d] !== 1'b0 || wa[d] !== 1'b0 || aerr[d] !== 1'b0 ||
             idone[d] !== 1'b0 || rdata[d] !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs dut%0d: got rv=%b wa=%b ae=%b id=%b d=%h, required all 0",
                     d, rv[d], wa[d], aerr[d], idone[d], rdata[d]);
         end
      end
      clear_model();
      repeat (2) @(posedge clk);
      release_and_measure(first);
      for (int d = 0; d < 2; d++) begin
         compared++;
         if (first[d] != exp_init[d]) begin
            mismatched++;
            $display("FAIL init_cycles dut%0d: got %0d, required %0d", d, first[d], exp_init[d]);
         end
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_init_clear();
      int lat;
      for (int a = 0; a < 16; a++) begin
         do_read(a, lat);
         compared++;
         if (lat != 3) begin
            mismatched++;
            $display("FAIL read_latency_clear a=%0d: got %0d, required 3", a, lat);
         end
      end
   endtask

   task automatic test_write_read();
      int lat;
      do_write(5, 16'h1234, 1'b0, lat);
      compared++;
      if (lat != 2) begin
         mismatched++;
         $display("FAIL write_ack_latency: got %0d, required 2", lat);
      end
      do_read(5, lat);
      compared++;
      if (lat != 3) begin
         mismatched++;
         $display("FAIL read_valid_latency: got %0d, required 3", lat);
      end
      for (int d = 0; d < 2; d++) begin
         compared++;
         if (rdata[d] !== 16'sh1234) begin
            mismatched++;
            $display("FAIL data_hold dut%0d: got %h, required 1234", d, rdata[d]);
         end
      end
   endtask

   task automatic test_collision();
      int      lat;
      rd_exp_t re;
      for (int d = 0; d < 2; d++) begin
         wr_q[d].push_back(1'b0);
         model[d][3] = 16'h00AA;
         re.data = 16'h00AA;
         re.err  = 1'b0;
         rd_q[d].push_back(re);
      end
      wr_addr = 4'd3; wdata = 16'sh00AA; rd_addr = 4'd3;
      wr_req = 1'b1; rd_req = 1'b1;
      wait_pulse(0, lat);
      compared++;
      if (lat != 2) begin
         mismatched++;
         $display("FAIL collision_write_first: ack after %0d, required 2", lat);
      end
      wr_req = 1'b0;
      wait_pulse(1, lat);
      compared++;
      if (lat != 4) begin
         mismatched++;
         $display("FAIL collision_read_after: valid after %0d, required 4", lat);
      end
      rd_req = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
   endtask

   task automatic test_back_to_back_hold();
      int lat;
      do_write(7, 16'h5A5A, 1'b1, lat);
      compared++;
      if (lat != 2) begin
         mismatched++;
         $display("FAIL held_write_ack: got %0d, required 2", lat);
      end
      do_write(8, 16'hC3C3, 1'b0, lat);
      do_read(7, lat);
      do_read(8, lat);
   endtask

   task automatic test_out_of_range();
      int lat;
      do_write(11, 16'h0BEE, 1'b0, lat);
      do_write(12, 16'h0C0C, 1'b0, lat);
      do_write(13, 16'h7777, 1'b0, lat);
      do_read(11, lat);
      do_read(12, lat);
      do_read(13, lat);
      compared++;
      if (lat != 3) begin
         mismatched++;
         $display("FAIL oor_read_latency: got %0d, required 3", lat);
      end
   endtask

   task automatic test_reset_mid_read();
      int first [2];
      int exp_init [2];
      int lat;
      exp_init = '{int'(SIZE_A), int'(SIZE_B)};
      rd_addr = 4'd5;
      rd_req  = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset_n = 1'b0;
      rd_req  = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         compared++;
         if (rv[d] !== 1'b0 || idone[d] !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_read_reset dut%0d: got rv=%b id=%b, required 0 0", d, rv[d], idone[d]);
         end
      end
      clear_model();
      repeat (2) @(posedge clk);
      release_and_measure(first);
      for (int d = 0; d < 2; d++) begin
         compared++;
         if (first[d] != exp_init[d]) begin
            mismatched++;
            $display("FAIL reinit_cycles dut%0d: got %0d, required %0d", d, first[d], exp_init[d]);
         end
      end
      repeat (2) begin @(posedge clk); #1; end
      do_read(5, lat);
      do_read(7, lat);
   endtask

   initial begin
      test_reset();
      test_init_clear();
      test_write_read();
      test_collision();
      test_back_to_back_hold();
      test_out_of_range();
      test_reset_mid_read();
      for (int d = 0; d < 2; d++) begin
         compared++;
         if (rd_q[d].size() != 0 || wr_q[d].size() != 0) begin
            mismatched++;
            $display("FAIL pending_responses dut%0d: got %0d reads %0d writes outstanding, required 0",
                     d, rd_q[d].size(), wr_q[d].size());
         end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/delay_mem_responder.md
DELAY_MEM_RESPONDER -- requirements
Module: delay_mem_responder

Interface
REQ-001 Parameter data_width, default 16, is the word width of stored samples.
REQ-002 Parameter memory_size, default 8192, is the number of words; addr_width SHALL be $clog2(memory_size).
REQ-003 Parameter read_latency, default 1, legal 1..4, is the RAM read pipeline depth in cycles.
REQ-004 clk  input  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 mem_read_req  input  1  read request, level, held by the initiator until mem_read_valid.
REQ-007 mem_write_req  input  1  write request, level, held by the initiator until mem_write_ack.
REQ-008 mem_read_addr  input  addr_width  read address, stable while mem_read_req is high.
REQ-009 mem_write_addr  input  addr_width  write address, stable while mem_write_req is high.
REQ-010 mem_data_out  input  data_width signed  write data from the initiator.
REQ-011 mem_data_in  output  data_width signed  read data to the initiator.
REQ-012 mem_read_valid  output  1  one-cycle pulse; mem_data_in is valid in that cycle.
REQ-013 mem_write_ack  output  1  one-cycle pulse; the write has been committed.
REQ-014 init_done  output  1  high once the post-reset clear sweep has finished.
REQ-015 addr_error  output  1  one-cycle pulse on an access with address >= memory_size.

Function
REQ-016 The FSM SHALL have the states INIT, IDLE, WRITE, READ and HOLD.
REQ-017 INIT SHALL write 0 to addresses 0..memory_size-1, one per cycle, then set init_done and enter IDLE; it takes exactly memory_size cycles.
REQ-018 Requests asserted during INIT SHALL NOT be acknowledged until INIT ends; they remain pending because they are level-held.
REQ-019 IDLE SHALL sample both request lines each cycle; if both are high, the write SHALL win and the read SHALL be served afterwards.
REQ-020 On a write grant at edge N, the responder SHALL latch address and data and enter WRITE.
REQ-021 In WRITE the RAM write SHALL occur at edge N+1, and mem_write_ack SHALL be high for the cycle following edge N+1.
REQ-022 On a read grant at edge N, the responder SHALL latch the address and enter READ.
REQ-023 mem_read_valid SHALL pulse for the single cycle after edge N+read_latency+1, with mem_data_in carrying the stored word in that cycle.
REQ-024 mem_data_in SHALL hold its last value until the next read completes.
REQ-025 After an ack or valid pulse the FSM SHALL enter HOLD and return to IDLE only once the served request line is sampled low; this prevents double-serving a request whose deassert lags by one cycle.
REQ-026 A read of an address written by the immediately preceding write SHALL return the new data (no stale read).
REQ-027 An out-of-range write SHALL be dropped, but the ack is still given; an out-of-range read SHALL return 0 with valid still given. Both SHALL pulse addr_error coincident with the ack or valid.
REQ-028 At most one transaction SHALL be outstanding at a time; mem_write_ack and mem_read_valid SHALL never be high together.

Reset
REQ-029 Asserting reset_n low SHALL immediately force state INIT, clear the sweep counter to 0, and drive mem_read_valid, mem_write_ack, addr_error, init_done and mem_data_in to 0.
REQ-030 Reset asserted mid-transaction SHALL abandon that transaction without an ack or valid pulse, and the clear sweep SHALL restart from address 0 after release.
REQ-031 RAM contents are not reset directly; they are cleared only by the INIT sweep.

Structure
REQ-032 The FSM state encodings and the DELAY_FORMAT and address-width derivation SHALL live in a shared package used by both this block and delay_master.
REQ-033 Storage SHALL be a single-port synchronous RAM sub-module, delay_mem_ram, with a read_latency-deep output pipeline; the FSM, sweep counter and handshake logic SHALL remain in the top level.

Verification
REQ-034 Release reset with memory_size=16 -> init_done rises exactly 16 cycles after release; reading any of addresses 0..15 returns 0.
REQ-035 Write 0x1234 to address 5, then read address 5 with read_latency=1 -> ack 2 cycles after the request, valid 3 cycles after the read request, mem_data_in=0x1234.
REQ-036 Assert mem_write_req (addr 3, 0x00AA) and mem_read_req (addr 3) in the same cycle -> write acked first, then the read returns 0x00AA.
REQ-037 Hold mem_write_req high for 1 cycle after the ack -> exactly one ack pulse and one RAM write.
REQ-038 memory_size=12, read address 13 -> valid with mem_data_in=0 and addr_error pulsed in the same cycle.
REQ-039 Assert reset_n low during READ -> no valid pulse; after release the sweep restarts and init_done reasserts after memory_size cycles.
